ttl_74f169_d: RTL and testbench
===============================

TTL_74F169_D -- requirements
Module: ttl_74F169_d

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 The module SHALL have parameter MODULUS, default 16, giving the count range 0..MODULUS-1; legal range is 2 <= MODULUS <= 2**WIDTH.
REQ-003 The module SHALL have port CLK, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The module SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port LOAD_n, input, 1 bit: synchronous parallel load, active-low.
REQ-006 The module SHALL have port U_D, input, 1 bit: count direction, 1 = up, 0 = down.
REQ-007 The module SHALL have port ENP_n, input, 1 bit: count enable P, active-low.
REQ-008 The module SHALL have port ENT_n, input, 1 bit: count enable T, active-low; also gates TC_n.
REQ-009 The module SHALL have port D, input, WIDTH bits: parallel load data.
REQ-010 The module SHALL have port Q, output, WIDTH bits: current count.
REQ-011 The module SHALL have port TC_n, output, 1 bit: terminal count, active-low, for cascading into ENT_n of the next stage or into a downstream D/CLK of a 74F74 flip-flop.

Function
REQ-012 The block SHALL apply priority at each rising CLK edge: RESET, then load, then count, then hold.
REQ-013 With LOAD_n=0, the block SHALL load Q <= D on the edge, regardless of ENP_n, ENT_n and U_D.
REQ-014 A load value D >= MODULUS SHALL be loaded unmodified, with no clipping.
REQ-015 With LOAD_n=1, ENP_n=0 and ENT_n=0, the block SHALL count one step in the direction given by U_D at that edge.
REQ-016 With LOAD_n=1 and either enable high, the block SHALL hold Q.
REQ-017 Up-count wrap: if Q >= MODULUS-1, the next Q SHALL be 0; otherwise Q+1.
REQ-018 Down-count wrap: if Q == 0, the next Q SHALL be MODULUS-1; otherwise Q-1, including from out-of-range values.
REQ-019 Count arithmetic SHALL be WIDTH bits with no carry beyond bit WIDTH-1; when MODULUS = 2**WIDTH, behaviour SHALL equal plain binary wrap.
REQ-020 TC_n SHALL be combinational from Q, U_D and ENT_n, with no register stage and no dependence on ENP_n or LOAD_n.
REQ-021 TC_n SHALL be 0 iff ENT_n=0 and either (U_D=1 and Q==MODULUS-1) or (U_D=0 and Q==0); otherwise TC_n SHALL be 1.
REQ-022 A change of U_D between edges SHALL alter only TC_n immediately; Q SHALL change only at the next edge.
REQ-023 Simultaneous LOAD_n=0 and enabled count SHALL perform the load only.
REQ-024 Cascade rule: stage k+1 ENT_n tied to stage k TC_n, with all ENP_n common, SHALL yield a synchronous multi-stage counter with no intermediate glitch on Q.

Reset
REQ-025 RESET=1 SHALL force Q=0 immediately, asynchronously, with no CLK edge required.
REQ-026 While RESET=1, Q SHALL remain 0 and SHALL ignore CLK, LOAD_n and the enables.
REQ-027 During reset, TC_n SHALL follow REQ-021 with Q=0, i.e. 0 iff ENT_n=0 and U_D=0.
REQ-028 On RESET deassertion, the first rising CLK edge after release SHALL be processed normally; RESET asserted mid-count SHALL discard the count in progress.
REQ-029 The Q register SHALL also initialise to 0 at time zero in simulation.

Verification
REQ-030 Scenario, up count: WIDTH=4, MODULUS=10, RESET pulse, then U_D=1, enables low, 12 edges -> Q sequence 1..9,0,1,2; TC_n=0 only while Q=9.
REQ-031 Scenario, down count: MODULUS=10, load D=2, then U_D=0, 4 edges -> Q=1,0,9,8; TC_n=0 only while Q=0.
REQ-032 Scenario, load priority and out-of-range value: LOAD_n=0, D=4'hC with enables low -> Q=C; next up edge -> Q=0; reload C, down edge -> Q=B.
REQ-033 Scenario, enable gating: ENP_n=1, ENT_n=0 at Q=9 up -> Q holds at 9, TC_n=0; ENT_n=1 -> TC_n=1 with no clock edge.
REQ-034 Scenario, asynchronous reset: RESET raised mid-cycle at Q=7 -> Q=0 before the next edge; LOAD_n=0 while RESET=1 -> Q stays 0.
REQ-035 Scenario, cascade: two instances with WIDTH=4, MODULUS=16, cascaded per REQ-024, 256 edges from 0 -> combined {Q_hi,Q_lo} counts 0..255 then 0; TC_n of the high stage is low only at 8'hFF.

Source files
------------

// File: rtl/ttl_74f169_d.sv
// Synchronous up/down modulo counter in the style of the 74F169:
// async reset, synchronous parallel load, cascadable terminal count.
module ttl_74f169_d #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOAD_n,
  input  logic             U_D,
  input  logic             ENP_n,
  input  logic             ENT_n,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC_n
);

  localparam logic [WIDTH-1:0] MaxV = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] One  = WIDTH'(1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] up_v;
  logic [WIDTH-1:0] dn_v;
  logic             ld;
  logic             cnt;
  logic             at_max;
  logic             at_zero;

  assign ld      = ~LOAD_n;
  assign cnt     = LOAD_n & ~ENP_n & ~ENT_n;
  assign at_max  = (q_q == MaxV);
  assign at_zero = (q_q == '0);

  // Out-of-range values above MaxV fold back to zero on the way up.
  always_comb begin
    up_v = q_q + One;
    if (q_q >= MaxV) begin
      up_v = '0;
    end
  end

  always_comb begin
    dn_v = q_q - One;
    if (at_zero) begin
      dn_v = MaxV;
    end
  end

  always_comb begin
    q_d = q_q;
    unique case (1'b1)
      ld:      q_d = D;
      cnt:     q_d = U_D ? up_v : dn_v;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // TC is purely combinational so cascaded stages see it within the cycle.
  always_comb begin
    TC_n = 1'b1;
    if (!ENT_n) begin
      TC_n = U_D ? ~at_max : ~at_zero;
    end
  end

  assign Q = q_q;

endmodule

// File: tb/tb_ttl_74f169_d.sv
// Bench for ttl_74f169_d: directed scenarios, random run
// against an arithmetic model, and a two-stage cascade.
module tb_ttl_74f169_d;

  logic       clk;
  logic       rst;
  logic       ld_n;
  logic       ud;
  logic       enp_n;
  logic       ent_n;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc_n;

  logic       c_rst;
  logic       c_enp_n;
  logic       c_ent_n;
  logic       c_ld_n;
  logic [3:0] q_lo;
  logic [3:0] q_hi;
  logic       tc_lo;
  logic       tc_hi;

  int total;
  int passed;
  int mq;

  localparam int M = 10;

  ttl_74f169_d #(.WIDTH(4), .MODULUS(M)) dut (
    .CLK(clk), .RESET(rst), .LOAD_n(ld_n), .U_D(ud),
    .ENP_n(enp_n), .ENT_n(ent_n), .D(d), .Q(q), .TC_n(tc_n)
  );

  ttl_74f169_d #(.WIDTH(4), .MODULUS(16)) u_lo (
    .CLK(clk), .RESET(c_rst), .LOAD_n(c_ld_n), .U_D(1'b1),
    .ENP_n(c_enp_n), .ENT_n(c_ent_n), .D(4'h0), .Q(q_lo), .TC_n(tc_lo)
  );

  ttl_74f169_d #(.WIDTH(4), .MODULUS(16)) u_hi (
    .CLK(clk), .RESET(c_rst), .LOAD_n(c_ld_n), .U_D(1'b1),
    .ENP_n(c_enp_n), .ENT_n(tc_lo), .D(4'h0), .Q(q_hi), .TC_n(tc_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nxt(int cur, bit l_n, bit u, bit p_n, bit t_n,
                             int dv, int m);
    if (!l_n) return dv;
    if (p_n || t_n) return cur;
    if (u) return (cur >= m - 1) ? 0 : cur + 1;
    return (cur == 0) ? m - 1 : cur - 1;
  endfunction

  function automatic int tcm(int cur, bit u, bit t_n, int m);
    if (t_n) return 1;
    if (u && cur == m - 1) return 0;
    if (!u && cur == 0) return 0;
    return 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_dut(input string tag);
    check({tag, "_q"}, 32'(q), 32'(mq));
    check({tag, "_tc"}, 32'(tc_n), 32'(tcm(mq, ud, ent_n, M)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) mq = 0;
    else mq = nxt(mq, ld_n, ud, enp_n, ent_n, int'(d), M);
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b1; ld_n = 1'b1; ud = 1'b0;
    enp_n = 1'b0; ent_n = 1'b0; d = 4'h0;
    c_rst = 1'b1; c_ld_n = 1'b1; c_enp_n = 1'b0; c_ent_n = 1'b0;
    mq = 0;
    #1;
    check("rst_q", 32'(q), 32'h0);
    check("rst_tc_dn", 32'(tc_n), 32'h0);
    ud = 1'b1;
    #1;
    check("rst_tc_up", 32'(tc_n), 32'h1);
    tick();
    check("rst_hold", 32'(q), 32'h0);

    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("up_seq", 32'(q), 32'((i + 1) % 10));
      check("up_tc", 32'(tc_n), (q == 4'd9) ? 32'h0 : 32'h1);
    end

    ld_n = 1'b0; d = 4'd2;
    tick();
    chk_dut("ld2");
    ld_n = 1'b1; ud = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dn_seq", 32'(q), 32'((11 - i) % 10));
      check("dn_tc", 32'(tc_n), (i == 1) ? 32'h0 : 32'h1);
    end

    ud = 1'b1; ld_n = 1'b0; d = 4'hC;
    tick();
    check("ld_c", 32'(q), 32'hC);
    ld_n = 1'b1;
    tick();
    check("up_from_c", 32'(q), 32'h0);
    ld_n = 1'b0;
    tick();
    ld_n = 1'b1; ud = 1'b0;
    tick();
    check("dn_from_c", 32'(q), 32'hB);

    ud = 1'b1; ld_n = 1'b0; d = 4'd9;
    tick();
    ld_n = 1'b1; enp_n = 1'b1;
    tick();
    check("gate_hold", 32'(q), 32'h9);
    check("gate_tc", 32'(tc_n), 32'h0);
    ent_n = 1'b1;
    #1;
    check("gate_tc_off", 32'(tc_n), 32'h1);
    enp_n = 1'b0; ent_n = 1'b0;

    ld_n = 1'b0; d = 4'd7;
    tick();
    ld_n = 1'b1;
    check("pre_arst", 32'(q), 32'h7);
    #2;
    rst = 1'b1;
    #1;
    mq = 0;
    check("arst_q", 32'(q), 32'h0);
    ld_n = 1'b0; d = 4'd5;
    tick();
    check("arst_ld", 32'(q), 32'h0);
    rst = 1'b0; ld_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      ld_n  = ($urandom_range(0, 5) == 0);
      ld_n  = ~ld_n;
      ud    = 1'($urandom);
      enp_n = ($urandom_range(0, 4) == 0);
      ent_n = ($urandom_range(0, 4) == 0);
      d     = 4'($urandom);
      rst   = ($urandom_range(0, 24) == 0);
      #1;
      if (rst) mq = 0;
      chk_dut("rnd_pre");
      tick();
      chk_dut("rnd_post");
    end
    rst = 1'b0;

    c_rst = 1'b0;
    check("cas_init", 32'({q_hi, q_lo}), 32'h0);
    for (int i = 0; i < 256; i++) begin
      tick();
      check("cas_val", 32'({q_hi, q_lo}), 32'((i + 1) % 256));
      check("cas_tc", 32'(tc_hi), (i == 254) ? 32'h0 : 32'h1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
